uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//   Byte-serialising UART transmitter, the send-side partner of the 8N1 receiver on the same link.
//   Accepts bytes over a valid/ready handshake into a one-entry holding register.
//   Drives the serial pin LSB-first: start bit (0), D0..D7, optional parity, stop bit (1).
//   Bit timing uses the same integer + fractional-accumulator scheme as the receiver,
//   so the two ends agree on the bit period without needing an exact clock divisor.
// PARAMETERS
//   CLK_FREQ   100_000_000  system clock frequency in Hz
//   BAUD_RATE  9600         line rate in bit/s; CNT_INT=CLK_FREQ/BAUD_RATE, CNT_FRAC=CLK_FREQ%BAUD_RATE
//   PARITY_ODD 0            only used with UART_TX_PARITY_EN: 0=even parity, 1=odd parity
// PORTS
//   clk          in   1  system clock; every register updates on its rising edge
//   rst_n        in   1  synchronous active-low reset
//   tx_data      in   8  byte to send; sampled only on the accept cycle
//   tx_valid     in   1  tx_data is valid
//   tx_ready     out  1  holding register is empty; a byte is accepted when tx_valid && tx_ready
//   uart_tx_pin  out  1  serial line output, registered, idles high
//   tx_busy      out  1  a frame is on the line (any state other than IDLE)
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge), also when it arrives mid-frame:
//     - uart_tx_pin=1, tx_busy=0, tx_ready=1.
//     - Holding register emptied, FSM forced to IDLE, counters and accumulator cleared.
//     - A partially sent frame is abandoned; it is not resumed.
//   FSM states: IDLE -> START -> DATA (8 bits) -> [PARITY] -> STOP -> IDLE, or STOP -> START.
//   IDLE:
//     - If the holding register is full, load the shift register, set the pin to 0 and go to START.
//     - Accept cycle at edge N => pin low at edge N+1, so the start bit begins one cycle after accept.
//   Bit period:
//     - On entering each bit, acc += CNT_FRAC.
//     - If the new acc >= BAUD_RATE: the bit lasts CNT_INT+1 clocks and acc -= BAUD_RATE.
//     - Otherwise the bit lasts CNT_INT clocks.
//     - acc is 32 bits wide and is cleared only when leaving IDLE.
//   DATA: shift the register right; bit index 0..7 drives D0..D7.
//   STOP: pin=1 for one bit period.
//     - At the end of STOP, if the holding register is full, go straight to START.
//       The frames are then back-to-back with no idle gap, and acc is not cleared.
//     - Otherwise go to IDLE.
//   Holding register:
//     - Filled on accept. tx_ready is low in the cycle after an accept.
//     - Emptied on the cycle the byte moves into the shift register.
//     - The next byte can be accepted during the current frame.
//     - Accept and drain in the same cycle: the new byte is kept and tx_ready stays low.
//   tx_valid while tx_ready=0: ignored. The sender must hold tx_data/tx_valid until accepted.
//   tx_data X outside the accept cycle: no effect.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     - A PARITY bit (^data ^ PARITY_ODD) is sent between D7 and STOP.
//     - The frame is 11 bits.
//   UART_TX_PARITY_EN undefined:
//     - There is no PARITY state, the frame is 10 bits (8N1), and PARITY_ODD is ignored.
// TESTING
//   T1: CLK_FREQ=1000, BAUD_RATE=100, send 0xA5.
//       -> pin 0 for 10 clk, then 1,0,1,0,0,1,0,1 at 10 clk each, then 1 for 10 clk.
//       -> tx_busy high for exactly 100 clk.
//   T2: defaults, send 0x00.
//       -> Bit lengths 10416,10417,10417 repeating.
//       -> Frame length 104166 clk (6 extended bits).
//   T3: T1 parameters, hold tx_valid with 0x11 then 0x22.
//       -> Second byte accepted during the first frame.
//       -> Start bit of frame 2 begins the cycle after frame 1's stop bit ends.
//       -> 200 clk total, no idle gap.
//   T4: T1 parameters, assert rst_n=0 for 1 clk during D3.
//       -> Pin=1, tx_busy=0, tx_ready=1 on the next edge.
//       -> A subsequent 0x3C is sent as a clean full frame.
//   T5: tx_valid pulsed while tx_ready=0.
//       -> Byte dropped, no change in the frame on the pin.
//   T6: UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07.
//       -> Parity bit=1, frame 110 clk at T1 rates.
//       -> Same test with PARITY_ODD=1 -> parity bit=0.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Byte-serialising UART transmitter (start, D0..D7 LSB-first,
//               optional parity, stop). A one-entry holding register takes
//               bytes over a valid/ready handshake. Bit timing uses an integer
//               count plus a fractional accumulator, so the average bit period
//               matches CLK_FREQ/BAUD_RATE exactly.
//               Optional feature macro: UART_TX_PARITY_EN (adds a parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx_pin,
    output logic       tx_busy
);

    localparam int unsigned CNT_INT  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_FRAC = CLK_FREQ % BAUD_RATE;

    localparam logic [31:0] INT_W  = 32'(CNT_INT);
    localparam logic [31:0] FRAC_W = 32'(CNT_FRAC);
    localparam logic [31:0] BAUD_W = 32'(BAUD_RATE);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]  state;
    logic [31:0] cnt;
    logic [31:0] acc;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic [7:0]  hold_data;
    logic        hold_full;

`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`else
    // Parity polarity has no meaning in the 8N1 build.
    logic        unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    logic        accept;
    logic        bit_tick;
    logic        drain;
    logic        enter_bit;
    logic [31:0] acc_base;
    logic [31:0] acc_sum;
    logic [31:0] acc_next;
    logic [31:0] cnt_load;

    assign tx_ready = !hold_full;
    assign tx_busy  = (state != IDLE);
    assign accept   = tx_valid && tx_ready;
    assign bit_tick = (cnt == 32'd0);

    // A byte moves from the holding register into the shift register when a
    // frame starts from idle or when a stop bit ends with another byte waiting.
    assign drain = hold_full &&
                   ((state == IDLE) || ((state == STOP) && bit_tick));

    // A new bit begins on every drain and on every bit end except STOP->IDLE.
    assign enter_bit = drain ||
                       ((state != IDLE) && (state != STOP) && bit_tick);

    // Length of the bit being entered: add the fractional remainder and
    // stretch the bit by one clock whenever a whole baud period has built up.
    always_comb begin
        acc_base = (state == IDLE) ? 32'd0 : acc;
        acc_sum  = acc_base + FRAC_W;
        acc_next = acc_sum;
        cnt_load = INT_W - 32'd1;
        if (acc_sum >= BAUD_W) begin
            acc_next = acc_sum - BAUD_W;
            cnt_load = INT_W;
        end
    end

    // Holding register: fill on accept, empty when the byte is drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (drain) begin
            hold_full <= 1'b0;
        end
    end

    // Bit timer: reload at each bit start, count down to zero within the bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 32'd0;
            acc <= 32'd0;
        end else if (enter_bit) begin
            cnt <= cnt_load;
            acc <= acc_next;
        end else if ((state != IDLE) && (cnt != 32'd0)) begin
            cnt <= cnt - 32'd1;
        end
    end

    // Frame sequencer: drives the registered pin and steps through the bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift       <= 8'h00;
            bit_idx     <= 3'd0;
            uart_tx_pin <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    uart_tx_pin <= 1'b1;
                    if (hold_full) begin
                        shift       <= hold_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit  <= (^hold_data) ^ (PARITY_ODD != 0);
`endif
                        uart_tx_pin <= 1'b0;
                        state       <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        uart_tx_pin <= shift[0];
                        shift       <= {1'b0, shift[7:1]};
                        bit_idx     <= 3'd0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            uart_tx_pin <= parity_bit;
                            state       <= PARITY;
`else
                            uart_tx_pin <= 1'b1;
                            state       <= STOP;
`endif
                        end else begin
                            uart_tx_pin <= shift[0];
                            shift       <= {1'b0, shift[7:1]};
                            bit_idx     <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        uart_tx_pin <= 1'b1;
                        state       <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        if (hold_full) begin
                            // Back-to-back frame: no idle gap, accumulator kept.
                            shift       <= hold_data;
`ifdef UART_TX_PARITY_EN
                            parity_bit  <= (^hold_data) ^ (PARITY_ODD != 0);
`endif
                            uart_tx_pin <= 1'b0;
                            state       <= START;
                        end else begin
                            state       <= IDLE;
                        end
                    end
                end
                default: begin
                    uart_tx_pin <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
